gpr_file_mp: RTL and testbench
==============================

# gpr_file_mp

Multi-ported general-purpose register file for the dual-issue decode stage, with a per-register busy scoreboard. It replaces the single-issue 2R1W file. Read port count, write port count, register count and data width are all parameters. Same-cycle writeback data is forwarded to the read ports, and each register carries a busy bit that is set at issue, cleared at writeback, and cleared in bulk on a pipeline flush. Register 0 is hard-wired to zero.

## Interface
- NREG, 32: number of architectural registers; power of two, at least 2. IW = $clog2(NREG).
- XLEN, 32: register width in bits.
- NRD, 4: number of read ports (2 per issue slot).
- NWR, 2: number of write ports, and also the number of allocate ports (1 per slot).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset: asynchronous, active-low.
- rd_idx  in  NRD*IW  read indices; port p uses bits [p*IW +: IW].
- rd_data  out  NRD*XLEN  read data, combinational.
- rd_busy  out  NRD  busy bit of each read register after same-cycle writeback; combinational.
- wr_en  in  NWR  per-port write enable.
- wr_idx  in  NWR*IW  write indices.
- wr_data  in  NWR*XLEN  write data.
- alloc_en  in  NWR  per-slot allocate; marks the destination busy.
- alloc_idx  in  NWR*IW  allocate indices.
- flush  in  1  clears every busy bit.
- busy_vec  out  NREG  registered busy bits; bit 0 is always 0.

## Operation
- Storage: NREG x XLEN array plus an NREG-bit busy vector.
- Async reset (rst_n low): every register goes to 0 and every busy bit to 0 immediately.
  - While reset is held, writes and allocates are ignored and forwarding is suppressed.
  - In reset, rd_data = 0, rd_busy = 0 and busy_vec = 0 for every port.
- Register 0:
  - Reads always return 0 with rd_busy = 0.
  - wr_en and alloc_en targeting index 0 are ignored, including for forwarding.
- Write commit, at the edge, for every port with wr_en = 1 and idx != 0.
  - If two ports write the same index, the higher-numbered port wins.
- Read, for each read port p with index i != 0:
  - If any write port w has wr_en = 1 and wr_idx = i, rd_data = wr_data of the highest-numbered such w (forwarding).
  - Otherwise rd_data = array[i].
- rd_busy[p] = busy[i] AND NOT (any enabled write port targets i this cycle).
  - Allocates in the same cycle do not affect rd_busy; they become visible next cycle.
- Busy next-state for register i != 0, in priority order:
  1. flush = 1 → 0.
  2. Else any alloc_en with alloc_idx = i → 1. A new producer overrides a same-cycle writeback of the old one.
  3. Else any wr_en with wr_idx = i → 0.
  4. Else hold.
- Both allocate ports naming the same index sets the bit once (idempotent).
- flush does not block data writes in the same cycle; those writes still commit.
- Writing a register that is not busy is legal: data commits and the busy bit stays 0.
- Index arithmetic is unsigned, IW bits wide, with no wrap handling needed since NREG = 2^IW.

## Timing
- Read latency is 0 cycles: rd_data and rd_busy are purely combinational from rd_idx, wr_*, and array/busy state.
- Write latency is 1 edge into the array, and the value is forwarded in the same cycle. A read of a just-written index in cycle N+1 returns the array value.
- Busy updates become visible on busy_vec and rd_busy one edge after alloc, write, or flush.
- Reset assertion takes effect mid-cycle with no clock required. On deassertion, the first commit happens at the first rising edge with rst_n high.
- There is no handshake and no stall: every enabled write and allocate is accepted in the cycle it is presented.

## Test plan
- Reset: hold rst_n = 0, drive wr_en = 2'b11 to idx 5/6 → rd_data = 0, busy_vec = 0. After release, read all 31 registers → 0.
- Forwarding priority: in one cycle, wr0 writes idx 7 ← 0x1111 and wr1 writes idx 7 ← 0x2222; read idx 7 on all NRD ports.
  - Same cycle → 0x2222.
  - Next cycle, no writes → 0x2222.
- Register 0: write idx 0 ← 0xDEAD and alloc idx 0 → rd_data = 0 both in the same cycle and the next; rd_busy = 0; busy_vec[0] = 0.
- Scoreboard lifecycle:
  - alloc idx 9 → next cycle busy_vec[9] = 1 and rd_busy = 1.
  - wr idx 9 ← 0x55 → same cycle rd_busy = 0 and rd_data = 0x55; next cycle busy_vec[9] = 0.
- Alloc/write race: busy[3] = 1, then in the same cycle wr idx 3 and alloc idx 3 → busy_vec[3] stays 1 and the array holds the written data.
- Flush: busy set on idx 4, 8, 12; assert flush together with alloc idx 20 and wr idx 4 ← 0xAB → next cycle busy_vec = 0 and array[4] = 0xAB.

Source files
------------

// File: rtl/gpr_file_mp.sv
// Multi-ported register file with per-register busy scoreboard for the dual-issue decode stage.
// Writeback data is forwarded combinationally to the read ports; register 0 reads as zero.
module gpr_file_mp #(
   parameter int NREG = 32,
   parameter int XLEN = 32,
   parameter int NRD  = 4,
   parameter int NWR  = 2,
   localparam int IW  = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NRD*IW-1:0]   rd_idx,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*IW-1:0]   wr_idx,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic [NWR-1:0]      alloc_en,
   input  logic [NWR*IW-1:0]   alloc_idx,
   input  logic                flush,
   output logic [NREG-1:0]     busy_vec
);

   logic [NREG*XLEN-1:0] mem_flat;
   logic [NREG-1:0]      fwd_hit;

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_reg
         if (gi == 0) begin : g_zero
            assign mem_flat[XLEN-1:0] = '0;
            assign busy_vec[0]        = 1'b0;
            assign fwd_hit[0]         = 1'b0;
         end else begin : g_live
            logic [XLEN-1:0] data_reg;
            logic [XLEN-1:0] data_next;
            logic            busy_reg;
            logic            busy_next;
            logic            wr_hit;
            logic            alloc_hit;

            // Later ports overwrite earlier ones, so the highest-numbered writer wins.
            always_comb begin
               wr_hit    = 1'b0;
               data_next = data_reg;
               for (int w = 0; w < NWR; w++) begin
                  if (wr_en[w] && (wr_idx[w*IW +: IW] == IW'(gi))) begin
                     wr_hit    = 1'b1;
                     data_next = wr_data[w*XLEN +: XLEN];
                  end
               end
            end

            always_comb begin
               alloc_hit = 1'b0;
               for (int w = 0; w < NWR; w++) begin
                  if (alloc_en[w] && (alloc_idx[w*IW +: IW] == IW'(gi)))
                     alloc_hit = 1'b1;
               end
            end

            // A new producer outranks the writeback of the previous one.
            always_comb begin
               busy_next = busy_reg;
               if (flush)
                  busy_next = 1'b0;
               else if (alloc_hit)
                  busy_next = 1'b1;
               else if (wr_hit)
                  busy_next = 1'b0;
            end

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  data_reg <= '0;
                  busy_reg <= 1'b0;
               end else begin
                  data_reg <= data_next;
                  busy_reg <= busy_next;
               end
            end

            assign mem_flat[gi*XLEN +: XLEN] = data_reg;
            assign busy_vec[gi]              = busy_reg;
            assign fwd_hit[gi]               = wr_hit;
         end
      end

      for (gi = 0; gi < NRD; gi++) begin : g_rd
         logic [IW-1:0]   idx;
         logic [XLEN-1:0] val;

         assign idx = rd_idx[gi*IW +: IW];

         always_comb begin
            val = mem_flat[idx*XLEN +: XLEN];
            for (int w = 0; w < NWR; w++) begin
               if (wr_en[w] && (wr_idx[w*IW +: IW] == idx))
                  val = wr_data[w*XLEN +: XLEN];
            end
            // Writes aimed at register 0 and anything seen during reset must not leak out.
            if (!rst_n || (idx == '0))
               val = '0;
         end

         assign rd_data[gi*XLEN +: XLEN] = val;
         assign rd_busy[gi]              = rst_n & busy_vec[idx] & ~fwd_hit[idx];
      end
   endgenerate

endmodule

// File: tb/tb_gpr_file_mp.sv
// Scoreboard bench for gpr_file_mp: a behavioural model predicts each cycle's read outputs.
module tb_gpr_file_mp;

   localparam int NREG = 32;
   localparam int XLEN = 32;
   localparam int NRD  = 4;
   localparam int NWR  = 2;
   localparam int IW   = 5;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NRD*IW-1:0]   rd_idx;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic [NWR-1:0]      wr_en;
   logic [NWR*IW-1:0]   wr_idx;
   logic [NWR*XLEN-1:0] wr_data;
   logic [NWR-1:0]      alloc_en;
   logic [NWR*IW-1:0]   alloc_idx;
   logic                flush;
   logic [NREG-1:0]     busy_vec;

   always #5 clk = ~clk;

   gpr_file_mp #(.NREG(NREG), .XLEN(XLEN), .NRD(NRD), .NWR(NWR)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_idx    (rd_idx),
      .rd_data   (rd_data),
      .rd_busy   (rd_busy),
      .wr_en     (wr_en),
      .wr_idx    (wr_idx),
      .wr_data   (wr_data),
      .alloc_en  (alloc_en),
      .alloc_idx (alloc_idx),
      .flush     (flush),
      .busy_vec  (busy_vec)
   );

   typedef struct {
      string               tag;
      logic [NRD*XLEN-1:0] data;
      logic [NRD-1:0]      busy;
      logic [NREG-1:0]     bv;
   } exp_t;

   logic [XLEN-1:0] m_mem [NREG];
   logic [NREG-1:0] m_busy;
   exp_t            sb [$];
   int              n_tests = 0;
   int              n_fail  = 0;
   int              n_txn   = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_idle();
      wr_en     = '0;
      wr_idx    = '0;
      wr_data   = '0;
      alloc_en  = '0;
      alloc_idx = '0;
      flush     = 1'b0;
   endtask

   task automatic set_wr(input int port, input int idx, input logic [XLEN-1:0] d);
      wr_en[port]                 = 1'b1;
      wr_idx[port*IW +: IW]       = idx[IW-1:0];
      wr_data[port*XLEN +: XLEN]  = d;
   endtask

   task automatic set_alloc(input int port, input int idx);
      alloc_en[port]             = 1'b1;
      alloc_idx[port*IW +: IW]   = idx[IW-1:0];
   endtask

   task automatic set_rd(input int a, input int b, input int c, input int d);
      rd_idx[0*IW +: IW] = a[IW-1:0];
      rd_idx[1*IW +: IW] = b[IW-1:0];
      rd_idx[2*IW +: IW] = c[IW-1:0];
      rd_idx[3*IW +: IW] = d[IW-1:0];
   endtask

   function automatic exp_t predict(input string tag);
      exp_t            e;
      logic [IW-1:0]   ri;
      logic [XLEN-1:0] d;
      logic            hit;
      e.tag  = tag;
      e.data = '0;
      e.busy = '0;
      e.bv   = '0;
      if (rst_n) begin
         e.bv = m_busy;
         for (int p = 0; p < NRD; p++) begin
            ri = rd_idx[p*IW +: IW];
            if (ri != 0) begin
               d   = m_mem[ri];
               hit = 1'b0;
               for (int w = 0; w < NWR; w++) begin
                  if (wr_en[w] && wr_idx[w*IW +: IW] == ri) begin
                     hit = 1'b1;
                     d   = wr_data[w*XLEN +: XLEN];
                  end
               end
               e.data[p*XLEN +: XLEN] = d;
               e.busy[p]              = m_busy[ri] && !hit;
            end
         end
      end
      return e;
   endfunction

   task automatic model_edge();
      logic [NREG-1:0] nb;
      logic            wh;
      logic            ah;
      nb = m_busy;
      for (int i = 1; i < NREG; i++) begin
         wh = 1'b0;
         ah = 1'b0;
         for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && wr_idx[w*IW +: IW] == IW'(i)) wh = 1'b1;
            if (alloc_en[w] && alloc_idx[w*IW +: IW] == IW'(i)) ah = 1'b1;
         end
         if (flush)   nb[i] = 1'b0;
         else if (ah) nb[i] = 1'b1;
         else if (wh) nb[i] = 1'b0;
      end
      for (int w = 0; w < NWR; w++) begin
         if (wr_en[w] && wr_idx[w*IW +: IW] != 0)
            m_mem[wr_idx[w*IW +: IW]] = wr_data[w*XLEN +: XLEN];
      end
      m_busy = nb;
   endtask

   // Called #1 after a rising edge with inputs already driven; ends #1 after the next edge.
   task automatic run_cycle(input string tag);
      exp_t e;
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) m_mem[i] = '0;
         m_busy = '0;
      end
      sb.push_back(predict(tag));
      #4;
      e = sb.pop_front();
      n_txn++;
      for (int p = 0; p < NRD; p++)
         check($sformatf("%s rd_data[%0d]", e.tag, p), rd_data[p*XLEN +: XLEN], e.data[p*XLEN +: XLEN]);
      check($sformatf("%s rd_busy", e.tag), rd_busy, e.busy);
      check($sformatf("%s busy_vec", e.tag), busy_vec, e.bv);
      $display("[TB] txn %0d %s rd_idx=%h rd_data=%h rd_busy=%b busy_vec=%h",
               n_txn, e.tag, rd_idx, rd_data, rd_busy, busy_vec);
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
   endtask

   initial begin
      rst_n  = 1'b0;
      rd_idx = '0;
      drive_idle();
      for (int i = 0; i < NREG; i++) m_mem[i] = '0;
      m_busy = '0;
      @(posedge clk);
      #1;

      // Writes and allocates held during reset must be ignored.
      set_wr(0, 5, 32'hAAAA_0005);
      set_wr(1, 6, 32'hBBBB_0006);
      set_alloc(0, 5);
      set_alloc(1, 6);
      set_rd(5, 6, 5, 6);
      run_cycle("rst_hold");
      run_cycle("rst_hold2");

      drive_idle();
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         set_rd(4*k, 4*k+1, 4*k+2, 4*k+3);
         run_cycle("rst_clear");
      end

      set_wr(0, 7, 32'h1111);
      set_wr(1, 7, 32'h2222);
      set_rd(7, 7, 7, 7);
      run_cycle("fwd_prio");
      drive_idle();
      run_cycle("fwd_commit");

      set_wr(0, 0, 32'hDEAD);
      set_alloc(0, 0);
      set_rd(0, 0, 0, 0);
      run_cycle("r0_same");
      drive_idle();
      run_cycle("r0_next");

      set_alloc(1, 9);
      set_rd(9, 0, 9, 7);
      run_cycle("alloc9");
      drive_idle();
      run_cycle("busy9");
      set_wr(1, 9, 32'h55);
      run_cycle("wb9");
      drive_idle();
      run_cycle("clear9");

      set_alloc(0, 3);
      set_rd(3, 3, 0, 9);
      run_cycle("alloc3");
      set_wr(0, 3, 32'h3333);
      set_alloc(1, 3);
      run_cycle("race3");
      drive_idle();
      run_cycle("race3_after");

      set_alloc(0, 4);
      set_alloc(1, 8);
      set_rd(4, 8, 12, 20);
      run_cycle("alloc4_8");
      drive_idle();
      set_alloc(0, 12);
      set_alloc(1, 12);
      run_cycle("alloc12");
      drive_idle();
      flush = 1'b1;
      set_alloc(0, 20);
      set_wr(1, 4, 32'hAB);
      run_cycle("flush");
      drive_idle();
      run_cycle("flush_after");

      for (int n = 0; n < 300; n++) begin
         drive_idle();
         flush = ($urandom_range(0, 15) == 0);
         for (int w = 0; w < NWR; w++) begin
            if ($urandom_range(0, 1) == 1) set_wr(w, int'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 2) == 0) set_alloc(w, int'($urandom_range(0, 7)));
         end
         set_rd(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 31)));
         run_cycle("rand");
      end

      // Reset asserted mid-cycle must clear outputs with no clock edge.
      drive_idle();
      set_alloc(0, 11);
      set_wr(0, 12, 32'hC0DE);
      set_rd(11, 12, 0, 11);
      run_cycle("pre_async");
      drive_idle();
      run_cycle("pre_async2");
      rst_n = 1'b0;
      run_cycle("async_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
